mp_diff_restorer: RTL and testbench
===================================

Name: mp_diff_restorer

Overview:
- Iterative multi-precision restorer: the inverse of the multi-precision magnitude subtractor.
- Given the magnitude difference D, the reference operand B and a sign bit, it reconstructs the original operand A.
- sign=0: A = B + D. sign=1: A = B - D.
- Processes ADDER_WIDTH bits per cycle with one shared adder. Parallel-in, word-serial compute, parallel-out.
- Sits in the datapath after the subtractor for verification and round-trip checks of the multi-precision add/sub units.

Parameters:
- OPERAND_WIDTH, 512, width of D, B and result. Must be a multiple of ADDER_WIDTH.
- ADDER_WIDTH, 64, width of the shared combinational adder slice.
- N_ITERATIONS, OPERAND_WIDTH/ADDER_WIDTH, number of word iterations (derived; do not override).

Ports:
- iClk  input  1  clock, rising-edge.
- iRstn  input  1  reset, asynchronous assert, active-low.
- iStart  input  1  start request; sampled only in IDLE.
- iDiff  input  OPERAND_WIDTH  magnitude difference D.
- iOpB  input  OPERAND_WIDTH  reference operand B.
- iSign  input  1  0: A=B+D; 1: A=B-D.
- oRes  output  OPERAND_WIDTH  reconstructed A (mod 2^OPERAND_WIDTH).
- oFlag  output  1  add mode: final carry-out (overflow). Sub mode: borrow (D>B).
- oBusy  output  1  high whenever FSM is not in IDLE.
- oDone  output  1  one-cycle pulse; oRes and oFlag are valid.

Behaviour:
- Reset (iRstn=0, asynchronous): FSM to IDLE; counter, operand registers, oRes, oFlag, oDone all 0. Takes effect immediately, including mid-operation; the partial result is discarded.
- States and transitions:
  - IDLE: iStart=1 -> LOAD; otherwise stay.
  - LOAD: capture iDiff, iOpB, iSign; counter=0 -> ADD.
  - ADD: one word per cycle; counter increments. After word N_ITERATIONS-1 -> DONE.
  - DONE: latch oFlag; set oDone -> IDLE.
- Operand inputs are sampled only at the LOAD edge. They may change freely afterwards.
- Per-word arithmetic, on LSB words of the B and D shift registers:
  - add: B_w + D_w + cin.
  - sub: B_w + ~D_w + cin.
  - First-word cin = iSign (1 in sub mode, 0 in add mode). Subsequent cin = registered carry-out of the previous word.
- Shift registers:
  - B and D registers shift right by ADDER_WIDTH each ADD cycle, zero-filled.
  - Result register loads the sum word into its MSB slice and shifts right by ADDER_WIDTH only in ADD. It holds in all other states.
- Flag:
  - oFlag = last carry-out in add mode; = inverted last carry-out in sub mode.
  - Registered at the DONE edge; held until the next LOAD.
- Timing: iStart sampled at edge 0 gives:
  - LOAD after edge 0.
  - Final result word written at edge N_ITERATIONS+1.
  - oDone=1 after edge N_ITERATIONS+2, for exactly one cycle. FSM is already in IDLE during that cycle.
  - With defaults: oDone after edge 10.
- oRes/oFlag hold their final values from the oDone cycle until the next operation's first ADD edge.
- Outputs during an operation: oRes shows partial shifted data; it is not valid until oDone.
- iStart while busy: ignored, no queuing.
- Back-to-back: iStart=1 during the oDone cycle is accepted, since the FSM is in IDLE.
- Simultaneous reset and start: reset wins.

Test Plan:
1. B=5, D=3, sign=0, pulse iStart -> oRes=8, oFlag=0; oDone high one cycle, exactly 10 edges after start; oBusy high for 10 cycles (LOAD, 8 ADD, DONE), low again in the oDone cycle.
2. B=5, D=3, sign=1 -> oRes=2, oFlag=0. Then B=0, D=1, sign=1 -> oRes=all ones (2^512-1), oFlag=1.
3. Cross-word carry: B=2^64-1, D=1, sign=0 -> oRes=2^64 (word1=1, word0=0), oFlag=0. Also B=2^64, D=1, sign=1 -> oRes=2^64-1, oFlag=0.
4. Overflow: B=2^512-1, D=1, sign=0 -> oRes=0, oFlag=1.
5. Hold iStart=1 continuously for 30 cycles with random operands -> operation restarts only in the oDone cycle; result matches the operands present at each LOAD; inputs changed mid-operation do not affect oRes.
6. Assert iRstn=0 during the 4th ADD cycle -> oRes, oFlag, oDone, oBusy go 0 immediately. After release, B=7, D=7, sign=1 -> oRes=0, oFlag=0, correct latency.

Source files
------------

// File: rtl/mp_diff_restorer_if.sv
// Operand/result bundle for the multi-precision difference restorer.
interface mp_diff_restorer_if #(
    parameter int unsigned OPERAND_WIDTH = 512
);
    logic                     iStart;
    logic [OPERAND_WIDTH-1:0] iDiff;
    logic [OPERAND_WIDTH-1:0] iOpB;
    logic                     iSign;
    logic [OPERAND_WIDTH-1:0] oRes;
    logic                     oFlag;
    logic                     oBusy;
    logic                     oDone;

    // Requester side: issues operands and start, observes result.
    modport master (
        output iStart, iDiff, iOpB, iSign,
        input  oRes, oFlag, oBusy, oDone
    );

    // Restorer side.
    modport slave (
        input  iStart, iDiff, iOpB, iSign,
        output oRes, oFlag, oBusy, oDone
    );
endinterface

// File: rtl/mp_diff_restorer.sv
// Word-serial restorer: rebuilds A = B + D (sign=0) or A = B - D (sign=1)
// one ADDER_WIDTH slice per cycle through a single shared adder.
module mp_diff_restorer #(
    parameter int unsigned OPERAND_WIDTH = 512,
    parameter int unsigned ADDER_WIDTH   = 64
) (
    input  logic              iClk,
    input  logic              iRstn,
    mp_diff_restorer_if.slave bus
);
    localparam int unsigned N_ITERATIONS = OPERAND_WIDTH / ADDER_WIDTH;
    localparam int unsigned CNT_W        = (N_ITERATIONS > 1) ? $clog2(N_ITERATIONS) : 1;
    localparam int unsigned SUM_W        = ADDER_WIDTH + 1;
    localparam int unsigned TOP_SHIFT    = OPERAND_WIDTH - ADDER_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [OPERAND_WIDTH-1:0] opB;
    logic [OPERAND_WIDTH-1:0] opD;
    logic [OPERAND_WIDTH-1:0] res;
    logic                     sign;
    logic                     carry;
    logic                     flag;
    logic                     busy;
    logic                     done;

    logic [ADDER_WIDTH-1:0]   wordB;
    logic [ADDER_WIDTH-1:0]   wordD;
    logic [SUM_W-1:0]         sumFull;

    // Shared adder on the low words; subtraction is B + ~D + 1 with the +1
    // coming in as the first-word carry.
    always_comb begin
        wordB   = opB[ADDER_WIDTH-1:0];
        wordD   = sign ? ~opD[ADDER_WIDTH-1:0] : opD[ADDER_WIDTH-1:0];
        sumFull = SUM_W'(wordB) + SUM_W'(wordD) + SUM_W'(carry);
    end

    // Control FSM plus operand/result shift registers and registered outputs.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state <= IDLE;
            cnt   <= '0;
            opB   <= '0;
            opD   <= '0;
            res   <= '0;
            sign  <= 1'b0;
            carry <= 1'b0;
            flag  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    opB   <= bus.iOpB;
                    opD   <= bus.iDiff;
                    sign  <= bus.iSign;
                    carry <= bus.iSign;
                    cnt   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    opB   <= opB >> ADDER_WIDTH;
                    opD   <= opD >> ADDER_WIDTH;
                    res   <= (res >> ADDER_WIDTH)
                           | (OPERAND_WIDTH'(sumFull[ADDER_WIDTH-1:0]) << TOP_SHIFT);
                    carry <= sumFull[ADDER_WIDTH];
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N_ITERATIONS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Sub mode: no final carry means a borrow (D > B).
                    flag  <= sign ? ~carry : carry;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oRes  = res;
    assign bus.oFlag = flag;
    assign bus.oBusy = busy;
    assign bus.oDone = done;

endmodule

// File: tb/tb_mp_diff_restorer.sv
// Directed bench for mp_diff_restorer with hand-computed expectations.
module tb_mp_diff_restorer;
    localparam int unsigned OW = 512;

    logic iClk;
    logic iRstn;
    int   total;
    int   bad;

    mp_diff_restorer_if #(.OPERAND_WIDTH(OW)) bus ();

    mp_diff_restorer #(.OPERAND_WIDTH(OW), .ADDER_WIDTH(64)) dut (
        .iClk  (iClk),
        .iRstn (iRstn),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [OW-1:0] rnd512();
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < OW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One full operation: start, scramble inputs after LOAD, measure latency and busy span.
    task automatic runOp(input logic [OW-1:0] b, input logic [OW-1:0] d, input logic s,
                         input logic [OW-1:0] expRes, input logic expFlag, input string tag);
        int lat;
        int busyCnt;
        bus.iOpB   = b;
        bus.iDiff  = d;
        bus.iSign  = s;
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        lat     = 0;
        busyCnt = 0;
        if (bus.oBusy) busyCnt++;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                bus.iOpB  = rnd512();
                bus.iDiff = rnd512();
                bus.iSign = ~s;
            end
            if (!bus.oDone && bus.oBusy) busyCnt++;
        end while (!bus.oDone && lat < 30);
        chk($sformatf("%s.latency", tag), OW'(lat), OW'(10));
        chk($sformatf("%s.busycycles", tag), OW'(busyCnt), OW'(10));
        chk($sformatf("%s.busy_at_done", tag), OW'(bus.oBusy), OW'(0));
        chk($sformatf("%s.res", tag), bus.oRes, expRes);
        chk($sformatf("%s.flag", tag), OW'(bus.oFlag), OW'(expFlag));
        tick();
        chk($sformatf("%s.done_pulse", tag), OW'(bus.oDone), OW'(0));
        chk($sformatf("%s.res_hold", tag), bus.oRes, expRes);
    endtask

    logic [OW-1:0] allOnes;
    logic [OW-1:0] w64;
    logic [OW-1:0] bArr [0:40];
    logic [OW-1:0] dArr [0:40];
    logic          sArr [0:40];
    logic [OW:0]   full;
    logic          expDone;
    int            k;

    initial begin
        total      = 0;
        bad        = 0;
        allOnes    = '1;
        w64        = '0;
        w64[64]    = 1'b1;
        iRstn      = 1'b0;
        bus.iStart = 1'b0;
        bus.iOpB   = '0;
        bus.iDiff  = '0;
        bus.iSign  = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst.res", bus.oRes, '0);
        chk("rst.flag", OW'(bus.oFlag), OW'(0));
        chk("rst.busy", OW'(bus.oBusy), OW'(0));
        chk("rst.done", OW'(bus.oDone), OW'(0));
        iRstn = 1'b1;
        tick();

        // Basic add / sub / borrow
        runOp(OW'(5), OW'(3), 1'b0, OW'(8), 1'b0, "add5p3");
        runOp(OW'(5), OW'(3), 1'b1, OW'(2), 1'b0, "sub5m3");
        runOp(OW'(0), OW'(1), 1'b1, allOnes, 1'b1, "sub0m1");

        // Cross-word carry and borrow
        runOp(w64 - OW'(1), OW'(1), 1'b0, w64, 1'b0, "carry64");
        runOp(w64, OW'(1), 1'b1, w64 - OW'(1), 1'b0, "borrow64");

        // Full-width overflow
        runOp(allOnes, OW'(1), 1'b0, OW'(0), 1'b1, "overflow");

        // iStart held high with fresh random operands every cycle:
        // captures at edges 1, 12, 23; done after edges 10, 21, 32.
        for (int c = 0; c < 36; c++) begin
            bus.iStart = (c < 30);
            bArr[c]    = rnd512();
            dArr[c]    = rnd512();
            sArr[c]    = 1'($urandom_range(0, 1));
            bus.iOpB   = bArr[c];
            bus.iDiff  = dArr[c];
            bus.iSign  = sArr[c];
            tick();
            expDone = (c == 10) || (c == 21) || (c == 32);
            chk($sformatf("hold.done%0d", c), OW'(bus.oDone), OW'(expDone));
            if (expDone) begin
                k = c - 9;
                if (sArr[k]) full = {1'b0, bArr[k]} - {1'b0, dArr[k]};
                else         full = {1'b0, bArr[k]} + {1'b0, dArr[k]};
                chk($sformatf("hold.res%0d", c), bus.oRes, full[OW-1:0]);
                chk($sformatf("hold.flag%0d", c), OW'(bus.oFlag), OW'(full[OW]));
            end
        end
        bus.iStart = 1'b0;
        tick();

        // Leave flag=1 and all-ones result, then reset during the 4th ADD cycle
        runOp(OW'(0), OW'(1), 1'b1, allOnes, 1'b1, "prerst");
        bus.iOpB   = OW'(0);
        bus.iDiff  = OW'(1);
        bus.iSign  = 1'b1;
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        repeat (4) tick();
        chk("midop.busy", OW'(bus.oBusy), OW'(1));
        chk("midop.flag", OW'(bus.oFlag), OW'(1));
        #2 iRstn = 1'b0;
        #1;
        chk("async.res", bus.oRes, '0);
        chk("async.flag", OW'(bus.oFlag), OW'(0));
        chk("async.done", OW'(bus.oDone), OW'(0));
        chk("async.busy", OW'(bus.oBusy), OW'(0));
        repeat (2) tick();
        iRstn = 1'b1;
        tick();
        chk("postrst.busy", OW'(bus.oBusy), OW'(0));
        runOp(OW'(7), OW'(7), 1'b1, OW'(0), 1'b0, "sub7m7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
